misr_compactor: RTL and testbench
=================================

// Module: misr_compactor
// PURPOSE
//  Multiple-input signature register (MISR) with a run-control FSM. It sits directly downstream of
//  the bus stage and consumes the DATA word that stage drives each test cycle.
//  It compacts a programmed number of response words into a WIDTH-bit signature.
//  It then compares the signature against a golden value and reports pass/fail to the LBIST controller.
// PARAMETERS
//  WIDTH    16       data/signature width; equals the BUS_WIDTH of the bus stage
//  POLY     16'h6801 feedback mask, shift-left Galois form (x^16+x^14+x^13+x^11+1)
//  SEED     16'hFFFF signature value loaded on START
//  COUNT_W  16       width of the pattern counter
// PORTS
//  CLK         in   1        rising-edge clock
//  RST_N       in   1        asynchronous, active-low reset
//  START       in   1        1-cycle pulse; arms a new run (honoured in IDLE and DONE only)
//  PATTERNS    in   COUNT_W  number of words to compact; sampled on START
//  GOLDEN      in   WIDTH    expected signature; sampled on START
//  DATA_VALID  in   1        DATA_IN carries a response word this cycle
//  DATA_IN     in   [0:WIDTH-1]  response word from the bus stage; bit 0 is the MSB
//  SIGNATURE   out  WIDTH    current MISR contents
//  BUSY        out  1        high in RUN
//  DONE        out  1        high in DONE; held until the next START or reset
//  PASS        out  1        valid while DONE=1; 1 iff SIGNATURE==latched GOLDEN
// BEHAVIOUR
//  Reset (RST_N=0, async):
//   - state=IDLE; SIGNATURE=0, BUSY=0, DONE=0, PASS=0; counter=0; golden latch=0.
//   - Reset mid-run abandons the run; no DONE is produced.
//  Treat DATA_IN as an unsigned value D (DATA_IN[0] = MSB).
//  Compaction step, with fb = S[WIDTH-1]:
//   - S_next = (S<<1 mod 2^WIDTH) ^ (fb ? POLY : 0) ^ D.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE/DONE + START:
//     - Load S=SEED, cnt=PATTERNS, latch GOLDEN; DONE=0 and PASS=0 at that edge.
//     - If PATTERNS!=0, go to RUN with BUSY=1.
//     - If PATTERNS==0, go straight to DONE; PASS=(SEED==GOLDEN).
//   - RUN + DATA_VALID:
//     - One compaction step per edge; cnt decrements.
//     - If cnt==1 at that edge, go to DONE at the same edge: BUSY=0, DONE=1, PASS=(S_next==golden).
//     - DONE/PASS are therefore valid the cycle after the last valid word, with zero added latency.
//   - RUN + !DATA_VALID: hold S and cnt; stalls of any length are allowed.
//   - RUN + START: ignored; a run cannot be restarted except by reset.
//   - DATA_VALID outside RUN: ignored; S is unchanged.
//   - DONE: S frozen; START (optionally with DATA_VALID) re-arms and ignores that cycle's data word.
//  Counter: unsigned; never wraps; the maximum run is 2^COUNT_W-1 words.
//  Outputs are registered only; no combinational path from inputs to outputs.
// TESTING
//  1. Single word: START with PATTERNS=1, GOLDEN=16'h6802; then VALID with D=16'hFFFD.
//     -> SIGNATURE=16'h6802, DONE=1, PASS=1 one cycle later.
//  2. Two words with a stall: PATTERNS=2; D=16'hFFFD, one idle cycle, then D=16'h0B56.
//     -> SIGNATURE goes 6802 then DB52; BUSY holds through the stall; DONE only after the 2nd word.
//  3. Mismatch: as test 1 but GOLDEN=16'h6803.
//     -> DONE=1, PASS=0, SIGNATURE=16'h6802.
//  4. Zero patterns: START with PATTERNS=0, GOLDEN=16'hFFFF.
//     -> next cycle DONE=1, PASS=1, SIGNATURE=16'hFFFF, BUSY never asserted.
//  5. Illegal control: START during RUN, and DATA_VALID in IDLE and DONE.
//     -> counter and signature undisturbed; run completes as if neither occurred.
//  6. Reset: RST_N low mid-run (after 1 of 3 words).
//     -> all outputs 0 immediately (async); a new START then runs cleanly from SEED.

Source files
------------

// File: rtl/misr_compactor.sv
// Multiple-input signature register with run-control FSM.
// Compacts a programmed number of response words into a signature. It then compares the
// signature against a latched golden value and reports pass/fail.
module misr_compactor #(
  parameter int unsigned     WIDTH   = 16,
  parameter logic [WIDTH-1:0] POLY   = 16'h6801,
  parameter logic [WIDTH-1:0] SEED   = 16'hFFFF,
  parameter int unsigned     COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] patterns,
  input  logic [WIDTH-1:0]   golden,
  input  logic               data_valid,
  input  logic [0:WIDTH-1]   data_in,
  output logic [WIDTH-1:0]   signature,
  output logic               busy,
  output logic               done,
  output logic               pass
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   sig_q;
  logic [WIDTH-1:0]   golden_q;
  logic [COUNT_W-1:0] cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;

  logic [WIDTH-1:0]   data_word;
  logic [WIDTH-1:0]   sig_step;
  logic               last_word;

  // Shift-left Galois step; data_in[0] lands on the signature MSB.
  always_comb begin
    data_word = data_in;
    sig_step  = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_word;
    last_word = (cnt_q == COUNT_W'(1));
  end

  // Run-control FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sig_q    <= '0;
      golden_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          // A data word presented alongside start is deliberately dropped.
          if (start) begin
            sig_q    <= SEED;
            golden_q <= golden;
            cnt_q    <= patterns;
            if (patterns != '0) begin
              state_q <= StRun;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
            end else begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (SEED == golden);
            end
          end
        end
        StRun: begin
          // start is ignored here; only reset can abandon a run.
          if (data_valid) begin
            sig_q <= sig_step;
            cnt_q <= cnt_q - COUNT_W'(1);
            if (last_word) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (sig_step == golden_q);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign signature = sig_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_misr_compactor.sv
// Directed, table-driven bench for misr_compactor.
module tb_misr_compactor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] patterns;
  logic [15:0] golden;
  logic        data_valid;
  logic [0:15] data_in;
  logic [15:0] signature;
  logic        busy;
  logic        done;
  logic        pass;

  int total;
  int bad;

  misr_compactor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .patterns   (patterns),
    .golden     (golden),
    .data_valid (data_valid),
    .data_in    (data_in),
    .signature  (signature),
    .busy       (busy),
    .done       (done),
    .pass       (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        start;
    logic [15:0] pat;
    logic [15:0] gold;
    logic        dv;
    logic [15:0] din;
    logic [15:0] sig;
    logic        busy;
    logic        done;
    logic        pass;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [15:0] s, input logic b,
                           input logic d, input logic p);
    check({name, ".sig"}, signature, s);
    check({name, ".busy"}, {15'd0, busy}, {15'd0, b});
    check({name, ".done"}, {15'd0, done}, {15'd0, d});
    check({name, ".pass"}, {15'd0, pass}, {15'd0, p});
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic cycle(input logic st, input logic [15:0] pat, input logic [15:0] gold,
                       input logic dv, input logic [15:0] din);
    start      = st;
    patterns   = pat;
    golden     = gold;
    data_valid = dv;
    data_in    = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // name, start, pat, gold, dv, din, exp sig, busy, done, pass
    vecs[0]  = '{"idle",        1'b0, 16'd0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"dv_in_idle",  1'b0, 16'd0, 16'h0000, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"t1_start",    1'b1, 16'd1, 16'h6802, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{"t1_word",     1'b0, 16'd0, 16'h0000, 1'b1, 16'hFFFD, 16'h6802, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{"dv_in_done",  1'b0, 16'd0, 16'h0000, 1'b1, 16'h5555, 16'h6802, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{"t3_start",    1'b1, 16'd1, 16'h6803, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{"t3_word",     1'b0, 16'd0, 16'h0000, 1'b1, 16'hFFFD, 16'h6802, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{"t2_start",    1'b1, 16'd2, 16'hDB52, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{"t2_word1",    1'b0, 16'd0, 16'h0000, 1'b1, 16'hFFFD, 16'h6802, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{"t2_stall",    1'b0, 16'd0, 16'h0000, 1'b0, 16'hFFFF, 16'h6802, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{"t2_word2",    1'b0, 16'd0, 16'h0000, 1'b1, 16'h0B56, 16'hDB52, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{"t4_start",    1'b1, 16'd0, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{"t4_hold",     1'b0, 16'd0, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{"rearm_dv",    1'b1, 16'd2, 16'hDB52, 1'b1, 16'hAAAA, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{"start_run",   1'b1, 16'd1, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{"start_dv",    1'b1, 16'd5, 16'h1111, 1'b1, 16'hFFFD, 16'h6802, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{"t5_word2",    1'b0, 16'd0, 16'h0000, 1'b1, 16'h0B56, 16'hDB52, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{"zero_miss",   1'b1, 16'd0, 16'h1234, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0};

    rst_n      = 1'b0;
    start      = 1'b0;
    patterns   = '0;
    golden     = '0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      cycle(vecs[i].start, vecs[i].pat, vecs[i].gold, vecs[i].dv, vecs[i].din);
      check_all(vecs[i].name, vecs[i].sig, vecs[i].busy, vecs[i].done, vecs[i].pass);
    end

    // Reset mid-run after one of three words.
    cycle(1'b1, 16'd3, 16'h0000, 1'b0, 16'h0000);
    check_all("t6_start", 16'hFFFF, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'd0, 16'h0000, 1'b1, 16'hFFFD);
    check_all("t6_word1", 16'h6802, 1'b1, 1'b0, 1'b0);
    data_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("t6_async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 16'd0, 16'h0000, 1'b1, 16'hFFFD);
    check_all("t6_post_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'd1, 16'h6802, 1'b0, 16'h0000);
    check_all("t6_restart", 16'hFFFF, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'd0, 16'h0000, 1'b1, 16'hFFFD);
    check_all("t6_rerun", 16'h6802, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
